// File: rtl/alu_result_serializer.sv
// alu_result_serializer: buffers ALU results in a small FIFO and streams each
// one as two bytes (low byte first) over a valid/ready byte interface.
// Results that arrive while the FIFO is full are dropped; a drop sets a
// sticky overflow flag.
module alu_result_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2*DATA_WIDTH-1:0]   alu_out_i,
  input  logic                      out_valid_i,
  output logic [DATA_WIDTH-1:0]     tx_data_o,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      busy_o,
  output logic                      ovf_o,
  input  logic                      ovf_clr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2} state_t;

  logic [2*DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    ovf_q, ovf_d;
  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   tx_data_q;
  // Only the upper byte of the popped result is still needed once the low
  // byte is on tx_data, so that is all the hold register keeps.
  logic [DATA_WIDTH-1:0]   hold_q;
  logic                    tx_valid_q;
  logic                    pop, push, drop;
  logic [2*DATA_WIDTH-1:0] head;

  assign head = mem_q[rd_ptr_q];

  // Push/pop decisions and next-state for pointers, occupancy and overflow.
  // A full FIFO still accepts a push when the serializer pops on that edge
  // (the write lands in the slot being vacated; the read sees the old data).
  always_comb begin
    pop      = (count_q != '0) &&
               ((state_q == IDLE) || ((state_q == HI) && tx_ready_i));
    push     = out_valid_i && ((count_q != CW'(DEPTH)) || pop);
    drop     = out_valid_i && !push;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    // A drop on the same edge as a clear keeps the flag set.
    ovf_d    = drop | (ovf_q & ~ovf_clr_i);
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= alu_out_i;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Serializer FSM: IDLE -> LO (low byte shown) -> HI (high byte shown),
  // chaining straight from HI to LO when another result is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            hold_q     <= head[2*DATA_WIDTH-1:DATA_WIDTH];
            tx_data_q  <= head[DATA_WIDTH-1:0];
            tx_valid_q <= 1'b1;
            state_q    <= LO;
          end
        end
        LO: begin
          if (tx_ready_i) begin
            tx_data_q <= hold_q;
            state_q   <= HI;
          end
        end
        HI: begin
          if (tx_ready_i) begin
            if (pop) begin
              hold_q    <= head[2*DATA_WIDTH-1:DATA_WIDTH];
              tx_data_q <= head[DATA_WIDTH-1:0];
              state_q   <= LO;
            end else begin
              tx_valid_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign count_o    = count_q;
  assign ovf_o      = ovf_q;
  assign busy_o     = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_alu_result_serializer.sv
// Bench for alu_result_serializer: directed scenario tasks plus a random
// traffic run, all checked against a byte-queue reference model.
module tb_alu_result_serializer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2*DW-1:0] alu_out_i = '0;
  logic            out_valid_i = 1'b0;
  logic [DW-1:0]   tx_data_o;
  logic            tx_valid_o;
  logic            tx_ready_i = 1'b0;
  logic [CW-1:0]   count_o;
  logic            busy_o;
  logic            ovf_o;
  logic            ovf_clr_i = 1'b0;

  int errors = 0;
  int checks = 0;

  // Reference model: bytes still owed to the transmitter, in order, plus
  // the expected overflow flag.
  logic [DW-1:0] exp_q[$];
  bit            exp_ovf = 1'b0;

  alu_result_serializer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_out_i  (alu_out_i),
    .out_valid_i(out_valid_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .count_o    (count_o),
    .busy_o     (busy_o),
    .ovf_o      (ovf_o),
    .ovf_clr_i  (ovf_clr_i)
  );

  always #5 clk = ~clk;

  // Model update at negedge (inputs are stable until the next posedge).
  // Capacity is DEPTH+1 results outstanding; a slot frees on the same edge
  // that the final (high) byte of the in-flight result is accepted.
  always @(negedge clk) begin
    int sz;
    int outstanding;
    bit hs, acc;
    logic [2*DW-1:0] v;
    if (rst_n) begin
      sz = exp_q.size();
      outstanding = (sz + 1) / 2;
      hs = tx_valid_o && tx_ready_i;
      checks++;
      if (ovf_o !== exp_ovf) begin
        errors++;
        $display("FAIL ovf_track: got %b expected %b at %0t", ovf_o, exp_ovf, $time);
      end
      if (hs) begin
        checks++;
        if (sz == 0) begin
          errors++;
          $display("FAIL stray_byte: got %h expected no byte at %0t", tx_data_o, $time);
        end else begin
          if (tx_data_o !== exp_q[0]) begin
            errors++;
            $display("FAIL byte_order: got %h expected %h at %0t", tx_data_o, exp_q[0], $time);
          end
          void'(exp_q.pop_front());
        end
      end
      acc = 1'b0;
      if (out_valid_i) begin
        acc = (outstanding <= DEPTH) || (hs && (sz % 2 == 1));
        v = alu_out_i;
        if (acc) begin
          exp_q.push_back(v[DW-1:0]);
          exp_q.push_back(v[2*DW-1:DW]);
        end
      end
      if (out_valid_i && !acc) exp_ovf = 1'b1;
      else if (ovf_clr_i)      exp_ovf = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({tx_valid_o, tx_data_o, count_o, ovf_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h c=%0d o=%b b=%b expected all zero",
               tx_valid_o, tx_data_o, count_o, ovf_o, busy_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    tx_ready_i = 1'b1;
    alu_out_i = 16'h1234; out_valid_i = 1'b1;
    step();
    out_valid_i = 1'b0;
    checks++;
    if (count_o !== CW'(1) || tx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_push: got c=%0d v=%b expected c=1 v=0", count_o, tx_valid_o);
    end
    step();
    checks++;
    if ({tx_valid_o, tx_data_o} !== {1'b1, 8'h34}) begin
      errors++;
      $display("FAIL single_lo: got v=%b d=%h expected v=1 d=34", tx_valid_o, tx_data_o);
    end
    step();
    checks++;
    if ({tx_valid_o, tx_data_o} !== {1'b1, 8'h12}) begin
      errors++;
      $display("FAIL single_hi: got v=%b d=%h expected v=1 d=12", tx_valid_o, tx_data_o);
    end
    step();
    checks++;
    if (tx_valid_o !== 1'b0 || busy_o !== 1'b0 || count_o !== '0) begin
      errors++;
      $display("FAIL single_idle: got v=%b b=%b c=%0d expected 0 0 0", tx_valid_o, busy_o, count_o);
    end
  endtask

  task automatic test_backpressure();
    tx_ready_i = 1'b0;
    alu_out_i = 16'hA5C3; out_valid_i = 1'b1;
    step();
    out_valid_i = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({tx_valid_o, tx_data_o} !== {1'b1, 8'hC3}) begin
        errors++;
        $display("FAIL bp_stall%0d: got v=%b d=%h expected v=1 d=c3", i, tx_valid_o, tx_data_o);
      end
      if (i < 4) step();
    end
    tx_ready_i = 1'b1;
    step();
    checks++;
    if ({tx_valid_o, tx_data_o} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL bp_hi: got v=%b d=%h expected v=1 d=a5", tx_valid_o, tx_data_o);
    end
    step();
    checks++;
    if (tx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: got v=%b expected v=0", tx_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_b [4];
    logic [CW-1:0] exp_c [4];
    exp_b = '{8'h02, 8'h01, 8'h04, 8'h03};
    exp_c = '{CW'(1), CW'(1), CW'(0), CW'(0)};
    tx_ready_i = 1'b1;
    alu_out_i = 16'h0102; out_valid_i = 1'b1;
    step();
    alu_out_i = 16'h0304;
    checks++;
    if (count_o !== CW'(1) || tx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got c=%0d v=%b expected c=1 v=0", count_o, tx_valid_o);
    end
    step();
    out_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({tx_valid_o, tx_data_o, count_o} !== {1'b1, exp_b[i], exp_c[i]}) begin
        errors++;
        $display("FAIL b2b_byte%0d: got v=%b d=%h c=%0d expected v=1 d=%h c=%0d",
                 i, tx_valid_o, tx_data_o, count_o, exp_b[i], exp_c[i]);
      end
      step();
    end
    checks++;
    if (tx_valid_o !== 1'b0 || ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got v=%b o=%b expected 0 0", tx_valid_o, ovf_o);
    end
  endtask

  task automatic test_overflow();
    int n;
    tx_ready_i = 1'b0;
    for (int r = 1; r <= 6; r++) begin
      alu_out_i = 16'(r); out_valid_i = 1'b1;
      step();
    end
    out_valid_i = 1'b0;
    checks++;
    if (ovf_o !== 1'b1 || count_o !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL ovf_full: got o=%b c=%0d expected o=1 c=%0d", ovf_o, count_o, DEPTH);
    end
    tx_ready_i = 1'b1;
    for (int r = 1; r <= 5; r++) begin
      for (int b = 0; b < 2; b++) begin
        logic [DW-1:0] e;
        e = (b == 0) ? DW'(r) : '0;
        checks++;
        if ({tx_valid_o, tx_data_o} !== {1'b1, e}) begin
          errors++;
          $display("FAIL ovf_drain r%0d b%0d: got v=%b d=%h expected v=1 d=%h",
                   r, b, tx_valid_o, tx_data_o, e);
        end
        step();
      end
    end
    checks++;
    if (tx_valid_o !== 1'b0 || ovf_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got v=%b o=%b expected v=0 o=1", tx_valid_o, ovf_o);
    end
    ovf_clr_i = 1'b1;
    step();
    ovf_clr_i = 1'b0;
    checks++;
    if (ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b expected 0", ovf_o);
    end
    // Refill; the dropping push coincides with a clear request.
    tx_ready_i = 1'b0;
    for (int r = 1; r <= 6; r++) begin
      alu_out_i = 16'h0100 + 16'(r); out_valid_i = 1'b1;
      ovf_clr_i = (r == 6);
      step();
    end
    out_valid_i = 1'b0;
    ovf_clr_i = 1'b0;
    checks++;
    if (ovf_o !== 1'b1 || count_o !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL ovf_set_wins: got o=%b c=%0d expected o=1 c=%0d", ovf_o, count_o, DEPTH);
    end
    ovf_clr_i = 1'b1;
    tx_ready_i = 1'b1;
    step();
    ovf_clr_i = 1'b0;
    n = 0;
    while (busy_o && n < 40) begin step(); n++; end
    checks++;
    if (busy_o !== 1'b0 || exp_q.size() != 0 || ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_redrain: got b=%b left=%0d o=%b expected 0 0 0", busy_o, exp_q.size(), ovf_o);
    end
  endtask

  task automatic test_wrap();
    logic [2*DW-1:0] v;
    logic [DW-1:0]   e;
    int got;
    tx_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      v = 16'($urandom);
      alu_out_i = v; out_valid_i = 1'b1;
      step();
      out_valid_i = 1'b0;
      got = 0;
      for (int cyc = 0; cyc < 8 && got < 2; cyc++) begin
        if (tx_valid_o) begin
          e = (got == 0) ? v[DW-1:0] : v[2*DW-1:DW];
          checks++;
          if (tx_data_o !== e) begin
            errors++;
            $display("FAIL wrap r%0d b%0d: got %h expected %h", k, got, tx_data_o, e);
          end
          got++;
        end
        step();
      end
      checks++;
      if (got != 2 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL wrap_done r%0d: got bytes=%0d busy=%b expected 2 0", k, got, busy_o);
      end
    end
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 400; i++) begin
      alu_out_i   = 16'($urandom);
      out_valid_i = ($urandom_range(2) != 0);
      tx_ready_i  = ($urandom_range(1) != 0);
      ovf_clr_i   = ($urandom_range(15) == 0);
      step();
    end
    out_valid_i = 1'b0;
    ovf_clr_i   = 1'b0;
    tx_ready_i  = 1'b1;
    n = 0;
    while (busy_o && n < 40) begin step(); n++; end
    checks++;
    if (busy_o !== 1'b0 || count_o !== '0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain: got b=%b c=%0d left=%0d expected 0 0 0", busy_o, count_o, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    int n;
    // Leave ovf set so the reset has something to clear.
    tx_ready_i = 1'b0;
    for (int r = 0; r < 6; r++) begin
      alu_out_i = 16'h7700 + 16'(r); out_valid_i = 1'b1;
      step();
    end
    out_valid_i = 1'b0;
    tx_ready_i = 1'b1;
    n = 0;
    while (busy_o && n < 40) begin step(); n++; end
    tx_ready_i = 1'b0;
    alu_out_i = 16'hBEEF; out_valid_i = 1'b1;
    step();
    alu_out_i = 16'h2233;
    step();
    alu_out_i = 16'h4455;
    step();
    out_valid_i = 1'b0;
    tx_ready_i = 1'b1;
    step();
    tx_ready_i = 1'b0;
    checks++;
    if ({tx_valid_o, tx_data_o, count_o, ovf_o} !== {1'b1, 8'hBE, CW'(2), 1'b1}) begin
      errors++;
      $display("FAIL rst_setup: got v=%b d=%h c=%0d o=%b expected v=1 d=be c=2 o=1",
               tx_valid_o, tx_data_o, count_o, ovf_o);
    end
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    #1;
    checks++;
    if ({tx_valid_o, tx_data_o, count_o, ovf_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL rst_async: got v=%b d=%h c=%0d o=%b b=%b expected all zero",
               tx_valid_o, tx_data_o, count_o, ovf_o, busy_o);
    end
    step();
    step();
    rst_n = 1'b1;
    tx_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL rst_stale%0d: got v=%b b=%b expected 0 0", i, tx_valid_o, busy_o);
      end
    end
    alu_out_i = 16'hC0DE; out_valid_i = 1'b1;
    step();
    out_valid_i = 1'b0;
    n = 0;
    while ((busy_o || exp_q.size() != 0) && n < 20) begin step(); n++; end
    checks++;
    if (busy_o !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_resume: got b=%b left=%0d expected 0 0", busy_o, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_wrap();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
